// File: rtl/barrett_reduce_pipe.sv
// Three-stage pipelined Barrett reducer: dout = din mod Q for din < Q*Q, with valid/ready and a sideband tag.
// Optional range flag on port range_err when BARRETT_RANGE_CHK_EN is defined.
module barrett_reduce_pipe #(
    parameter int Q     = 2671,
    parameter int K     = 12,
    parameter int DIN_W = 2*K,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DIN_W-1:0] din,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [K-1:0]     dout,
    output logic [TAG_W-1:0] out_tag
`ifdef BARRETT_RANGE_CHK_EN
    ,
    output logic             range_err
`endif
);

    localparam logic [2*K:0] MU   = (2*K+1)'((64'd1 << (2*K)) / 64'(Q));
    localparam logic [K+1:0] Q_R  = (K+2)'(Q);
    localparam logic [K+1:0] Q2_R = (K+2)'(2*Q);

    logic             en;
    logic [2*K:0]     p_c;
    logic [K+1:0]     r_c;
    logic [K-1:0]     dout_c;

    // S1 keeps only t = p >> K and the low K+2 din bits; that is all S2 consumes.
    logic             s1_valid;
    logic [K:0]       s1_t;
    logic [K+1:0]     s1_din_lo;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [K+1:0]     s2_r;
    logic [TAG_W-1:0] s2_tag;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        p_c = (2*K+1)'(din[DIN_W-1:K]) * MU;
        // Modular K+2-bit arithmetic is exact since the true remainder is below 3Q < 2**(K+2).
        r_c = s1_din_lo - (K+2)'(s1_t) * Q_R;
        if (s2_r >= Q2_R)
            dout_c = K'(s2_r - Q2_R);
        else if (s2_r >= Q_R)
            dout_c = K'(s2_r - Q_R);
        else
            dout_c = K'(s2_r);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_t      <= '0;
            s1_din_lo <= '0;
            s1_tag    <= '0;
            s2_valid  <= 1'b0;
            s2_r      <= '0;
            s2_tag    <= '0;
            out_valid <= 1'b0;
            dout      <= '0;
            out_tag   <= '0;
        end else if (en) begin
            s1_valid  <= in_valid && in_ready;
            s1_t      <= p_c[2*K:K];
            s1_din_lo <= din[K+1:0];
            s1_tag    <= in_tag;
            s2_valid  <= s1_valid;
            s2_r      <= r_c;
            s2_tag    <= s1_tag;
            out_valid <= s2_valid;
            dout      <= dout_c;
            out_tag   <= s2_tag;
        end
    end

`ifdef BARRETT_RANGE_CHK_EN
    localparam logic [DIN_W:0] QQ = (DIN_W+1)'(Q*Q);

    logic s1_err;
    logic s2_err;
    logic s3_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_err <= 1'b0;
            s2_err <= 1'b0;
            s3_err <= 1'b0;
        end else if (en) begin
            s1_err <= ({1'b0, din} >= QQ);
            s2_err <= s1_err;
            s3_err <= s2_err;
        end
    end

    assign range_err = out_valid && s3_err;
`endif

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Directed and randomized self-checking bench for barrett_reduce_pipe (Q=2671, K=12).
module tb_barrett_reduce_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] din;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] dout;
    logic [3:0]  out_tag;
`ifdef BARRETT_RANGE_CHK_EN
    logic        range_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    barrett_reduce_pipe #(.Q(2671), .K(12), .DIN_W(24), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .din(din), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .out_tag(out_tag)
`ifdef BARRETT_RANGE_CHK_EN
        , .range_err(range_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        in_valid = 1'b0; out_ready = 1'b0; din = '0; in_tag = '0;
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (out_valid !== 1'b0 || dout !== 12'd0 || out_tag !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: out_valid=%b dout=%0d tag=%h, want 0/0/0", out_valid, dout, out_tag);
        end
        @(negedge clk); rst_n = 1'b1;
        // fill with out_ready low so a nonzero result sits on dout
        in_valid = 1'b1; din = 24'd2000; in_tag = 4'h7;
        @(negedge clk); in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || dout !== 12'd2000) begin
            n_fail++;
            $display("FAIL reset_prefill: out_valid=%b dout=%0d, want 1/2000", out_valid, dout);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || dout !== 12'd0 || out_tag !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_async: out_valid=%b dout=%0d tag=%h, want 0/0/0", out_valid, dout, out_tag);
        end
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] vin [4];
        logic [11:0] vexp [4];
        vin[0] = 24'd0; vin[1] = 24'd2670; vin[2] = 24'd2671; vin[3] = 24'd5000000;
        vexp[0] = 12'd0; vexp[1] = 12'd2670; vexp[2] = 12'd0; vexp[3] = 12'd2559;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i < 4) begin
                in_valid = 1'b1; din = vin[i]; in_tag = 4'(i + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            n_checks++;
            if (i >= 3 && i < 7) begin
                if (out_valid !== 1'b1 || dout !== vexp[i-3] || out_tag !== 4'(i - 2)) begin
                    n_fail++;
                    $display("FAIL b2b_out[%0d]: valid=%b dout=%0d tag=%h, want 1/%0d/%h",
                             i - 3, out_valid, dout, out_tag, vexp[i-3], 4'(i - 2));
                end
            end else if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_idle[%0d]: out_valid=%b, want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_max_tag();
        out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b1; din = 24'd7134240; in_tag = 4'hA;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || dout !== 12'd2670 || out_tag !== 4'hA) begin
            n_fail++;
            $display("FAIL max_tag: valid=%b dout=%0d tag=%h, want 1/2670/a", out_valid, dout, out_tag);
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] vin [3];
        logic [11:0] vexp [3];
        vin[0] = 24'd1000; vin[1] = 24'd2000; vin[2] = 24'd3000;
        vexp[0] = 12'd1000; vexp[1] = 12'd2000; vexp[2] = 12'd329;
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); in_valid = 1'b1; din = vin[i]; in_tag = 4'(8 + i);
        end
        @(negedge clk); in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || dout !== 12'd1000 || out_tag !== 4'h8) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: in_ready=%b valid=%b dout=%0d tag=%h, want 0/1/1000/8",
                         i, in_ready, out_valid, dout, out_tag);
            end
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk); out_ready = 1'b1; #1;
            n_checks++;
            if (out_valid !== 1'b1 || dout !== vexp[j] || out_tag !== 4'(8 + j)) begin
                n_fail++;
                $display("FAIL bp_drain[%0d]: valid=%b dout=%0d tag=%h, want 1/%0d/%h",
                         j, out_valid, dout, out_tag, vexp[j], 4'(8 + j));
            end
        end
        @(negedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_random();
        logic [11:0] q_dout [$];
        logic [3:0]  q_tag [$];
        int          n_out = 0;
        int          n_in  = 0;
        logic [11:0] e_d;
        logic [3:0]  e_t;
        for (int c = 0; c < 10000 + 12; c++) begin
            @(negedge clk);
            if (c < 10000) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 7);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            din    = 24'($urandom_range(0, 7134240));
            in_tag = 4'($urandom_range(0, 15));
            #1;
            if (out_valid && out_ready) begin
                n_checks++;
                if (q_dout.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: dout=%0d emitted with nothing outstanding", dout);
                end else begin
                    e_d = q_dout.pop_front();
                    e_t = q_tag.pop_front();
                    if (dout !== e_d || out_tag !== e_t) begin
                        n_fail++;
                        $display("FAIL rand_out[%0d]: dout=%0d tag=%h, want %0d/%h", n_out, dout, out_tag, e_d, e_t);
                    end
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                q_dout.push_back(12'(din % 24'd2671));
                q_tag.push_back(in_tag);
                n_in++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (q_dout.size() != 0 || n_in != n_out || n_in < 1000) begin
            n_fail++;
            $display("FAIL rand_count: accepted=%0d emitted=%0d left=%0d", n_in, n_out, q_dout.size());
        end
    endtask

`ifdef BARRETT_RANGE_CHK_EN
    task automatic test_range();
        out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b1; din = 24'd7134241;
        @(negedge clk); din = 24'd7134240;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || range_err !== 1'b1) begin
            n_fail++;
            $display("FAIL range_hi: valid=%b range_err=%b, want 1/1", out_valid, range_err);
        end
        @(negedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || range_err !== 1'b0) begin
            n_fail++;
            $display("FAIL range_ok: valid=%b range_err=%b, want 1/0", out_valid, range_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_max_tag();
        test_backpressure();
`ifdef BARRETT_RANGE_CHK_EN
        test_range();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
